// File: rtl/operand_loader.sv
// Assembles operand words from a data button and a shift button, one bit per shift press.
// Define OPERAND_LOADER_DEBOUNCE_EN to compile in per-button debouncing.
module operand_loader #(
  parameter int unsigned width_p           = 8,
  parameter int unsigned debounce_cycles_p = 120000
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           bit_async_i,
  input  logic                           shift_async_i,
  input  logic                           clear_i,
  input  logic                           ready_i,
  output logic                           valid_o,
  output logic [width_p-1:0]             data_o,
  output logic [$clog2(width_p+1)-1:0]   count_o,
  output logic                           drop_o
);

  localparam int unsigned CountW = $clog2(width_p + 1);

  typedef enum logic [0:0] {StCollect, StFull} state_e;

  logic bit_s1_q, bit_s2_q, shift_s1_q, shift_s2_q;
  logic [1:0] sync_vld_q;
  logic bit_lvl, shift_lvl;
  logic shift_prev_q, arm_q, shift_evt;

  state_e              state_q, state_d;
  logic [width_p-1:0]  data_q, data_d;
  logic [CountW-1:0]   count_q, count_d;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      bit_s1_q   <= 1'b0;
      bit_s2_q   <= 1'b0;
      shift_s1_q <= 1'b0;
      shift_s2_q <= 1'b0;
      sync_vld_q <= '0;
    end else begin
      bit_s1_q   <= bit_async_i;
      bit_s2_q   <= bit_s1_q;
      shift_s1_q <= shift_async_i;
      shift_s2_q <= shift_s1_q;
      sync_vld_q <= {sync_vld_q[0], 1'b1};
    end
  end

`ifdef OPERAND_LOADER_DEBOUNCE_EN
  localparam int unsigned DbW = $clog2(debounce_cycles_p);
  localparam logic [DbW-1:0] DbMax = DbW'(debounce_cycles_p - 1);

  logic [DbW-1:0] bit_cnt_q, bit_cnt_d, shift_cnt_q, shift_cnt_d;
  logic           bit_db_q, bit_db_d, shift_db_q, shift_db_d;

  always_comb begin
    bit_cnt_d   = '0;
    bit_db_d    = bit_db_q;
    shift_cnt_d = '0;
    shift_db_d  = shift_db_q;
    if (bit_s2_q != bit_db_q) begin
      if (bit_cnt_q == DbMax) bit_db_d = bit_s2_q;
      else                    bit_cnt_d = bit_cnt_q + DbW'(1);
    end
    if (shift_s2_q != shift_db_q) begin
      if (shift_cnt_q == DbMax) shift_db_d = shift_s2_q;
      else                      shift_cnt_d = shift_cnt_q + DbW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      bit_cnt_q   <= '0;
      bit_db_q    <= 1'b0;
      shift_cnt_q <= '0;
      shift_db_q  <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      bit_db_q    <= bit_db_d;
      shift_cnt_q <= shift_cnt_d;
      shift_db_q  <= shift_db_d;
    end
  end

  assign bit_lvl   = bit_db_q;
  assign shift_lvl = shift_db_q;
`else
  logic unused_dbc;
  assign unused_dbc = (debounce_cycles_p != 0);
  assign bit_lvl    = bit_s2_q;
  assign shift_lvl  = shift_s2_q;
`endif

  // Events are armed only once the shift button has been seen released after reset,
  // so a button held through reset never produces a spurious press.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      shift_prev_q <= 1'b0;
      arm_q        <= 1'b0;
    end else begin
      shift_prev_q <= shift_lvl;
      arm_q        <= arm_q | (sync_vld_q[1] & ~shift_s2_q & ~shift_lvl);
    end
  end

  assign shift_evt = shift_lvl & ~shift_prev_q & arm_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    drop_o  = 1'b0;
    unique case (state_q)
      StCollect: begin
        if (clear_i) begin
          data_d  = '0;
          count_d = '0;
        end else if (shift_evt) begin
          data_d  = {data_q[width_p-2:0], bit_lvl};
          count_d = count_q + CountW'(1);
          if (count_q == CountW'(width_p - 1)) state_d = StFull;
        end
      end
      StFull: begin
        drop_o = shift_evt;
        if (ready_i) begin
          state_d = StCollect;
          data_d  = '0;
          count_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= StCollect;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign valid_o = (state_q == StFull);
  assign data_o  = data_q;
  assign count_o = count_q;

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 Parameter width_p, default 8: bits per assembled operand word (valid range 2..32).
REQ-002 Parameter debounce_cycles_p, default 120000: consecutive stable cycles required to accept a new button level (valid range 2..2^20).
REQ-003 clk_i  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset_n_i  input  1  reset, synchronous, active-low.
REQ-005 bit_async_i  input  1  raw data button level (1 = pressed); asynchronous to clk_i and not debounced.
REQ-006 shift_async_i  input  1  raw shift button level (1 = pressed); asynchronous and not debounced.
REQ-007 clear_i  input  1  synchronous pulse that aborts a partially assembled word.
REQ-008 ready_i  input  1  downstream (systolic array) can accept a word.
REQ-009 valid_o  output  1  data_o holds a complete word.
REQ-010 data_o  output  width_p  assembled word.
REQ-011 count_o  output  $clog2(width_p+1)  number of bits captured so far in the current word.
REQ-012 drop_o  output  1  one-cycle pulse when a shift press is discarded.

Function
REQ-013 Each async input shall pass through a 2-flop synchronizer before any other logic uses it.
REQ-014 Debounce: a per-input counter increments while the synchronized level differs from the debounced level; it resets to 0 on any match; when it reaches debounce_cycles_p-1, the debounced level takes the new value the next cycle.
REQ-015 A shift event shall be one cycle, on the debounced shift rising edge only; release and held levels generate nothing.
REQ-016 On a shift event in COLLECT: data shifts left, debounced bit enters the LSB, count_o increments (first bit entered becomes MSB).
REQ-017 The FSM shall have two states: COLLECT (valid_o=0) and FULL (valid_o=1).
REQ-018 COLLECT -> FULL in the same cycle count_o would reach width_p; valid_o is high from the next cycle and count_o reads width_p.
REQ-019 In FULL, data_o and count_o shall be held stable until the cycle where valid_o & ready_i; that cycle completes the transfer (exactly one word per handshake).
REQ-020 Transfer: next cycle valid_o=0, count_o=0, data_o=0, state COLLECT.
REQ-021 A shift event in FULL, including the transfer cycle, shall be discarded and drop_o pulsed for that cycle.
REQ-022 valid_o shall not depend combinationally on ready_i.
REQ-023 clear_i in COLLECT: next cycle count_o=0, data_o=0; a simultaneous shift event is discarded without drop_o.
REQ-024 clear_i in FULL shall be ignored; the pending word is never lost.

Reset
REQ-025 While reset_n_i=0 at a clock edge: state COLLECT, valid_o=0, data_o=0, count_o=0, drop_o=0, debounce counters 0, debounced levels 0, synchronizer flops 0.
REQ-026 Reset asserted in FULL or mid-word discards all content; no shift event shall be produced by a button already held when reset releases until it is released and pressed again.

Configuration
REQ-027 Macro OPERAND_LOADER_DEBOUNCE_EN: when defined, debouncing per REQ-014 is compiled in.
REQ-028 Without OPERAND_LOADER_DEBOUNCE_EN, debounce counters are removed and debounced level equals the synchronized level (input-to-effect latency 3 cycles); debounce_cycles_p is then unused.

Verification (macro defined, debounce_cycles_p=4, width_p=8 unless stated)
REQ-029 Enter bits 1,0,1,0,0,1,0,1 via clean presses, ready_i=0 -> valid_o=1, data_o=0xA5, count_o=8, held unchanged 20 cycles; ready_i=1 one cycle -> valid_o=0, count_o=0 next cycle.
REQ-030 Shift glitch of 2 cycles high then low -> no shift event, count_o unchanged; stable 10-cycle press -> count_o increments by exactly 1.
REQ-031 Word 0xFF pending, ready_i=0, one shift press -> drop_o one pulse, data_o stays 0xFF, count_o stays 8.
REQ-032 After 3 bits, clear_i pulse coincident with shift event -> count_o=0, data_o=0, drop_o=0; with valid_o=1, clear_i -> no change.
REQ-033 Reset_n_i low for 1 cycle after 5 bits with shift held -> all outputs 0; continued hold produces no event; release and press -> count_o=1.
REQ-034 Build without OPERAND_LOADER_DEBOUNCE_EN -> 1-cycle shift press counts one bit, count_o updates 3 cycles after input edge.
